astable_monitor: RTL

Receive-side companion to the 555 astable oscillator model. Samples the oscillator output asynchronously and synchronizes it. Measures high time, low time and period in system-clock cycles, and publishes each complete measurement through a valid/ready handshake. Flags a stalled oscillator (no edge within a timeout) and result overrun. It sits between the mixed-signal oscillator output and digital checkers or scoreboards.

---
 rtl/astable_mon_pkg.sv | 23 ++
 rtl/astable_monitor_edge_sync.sv | 37 +++
 rtl/astable_monitor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/astable_mon_pkg.sv
// Shared types and defaults for the 555 astable receive-side monitor.
//   state_t : measurement FSM states
//   meas_t  : one complete measurement at the default counter width
package astable_mon_pkg;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT     = 50000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  // Measurement payload as seen by scoreboards at the default width.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] high;
    logic [DEF_CNT_W-1:0] low;
    logic [DEF_CNT_W:0]   period;
  } meas_t;

endpackage

// File: rtl/astable_monitor_edge_sync.sv
// Multi-flop synchronizer for the asynchronous oscillator output plus
// single-cycle rise/fall pulse generation.
//   clk, rst   : system clock, async active-high reset
//   async_i    : asynchronous input
//   level_o    : synchronized level (last synchronizer stage)
//   rise_p_c   : 1-cycle pulse on a synchronized rising edge
//   fall_p_c   : 1-cycle pulse on a synchronized falling edge
module astable_monitor_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_p_c,
  output logic fall_p_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Synchronizer chain plus one delayed copy of its output for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o  = sync_q[SYNC_STAGES-1];
  assign rise_p_c = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_p_c = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/astable_monitor.sv
// Measures high time, low time and period of an asynchronous oscillator
// in clk cycles and publishes each full cycle over valid/ready.
//   clk, rst      : system clock, async active-high reset
//   osc_in        : asynchronous oscillator output
//   en            : measurement enable
//   meas_valid    : measurement held, waiting for meas_ready
//   meas_ready    : consumer accepts the held measurement
//   high_cnt      : cycles the oscillator was high
//   low_cnt       : cycles the oscillator was low
//   period        : high_cnt + low_cnt
//   overrun       : sticky, a held measurement was overwritten
//   stuck         : no edge for TIMEOUT cycles while measuring
//   stuck_level   : synchronized level when stuck was declared
module astable_monitor
  import astable_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             en,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             overrun,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic level_c;
  logic rise_c;
  logic fall_c;
  logic edge_c;
  logic tmo_c;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_ph_q, high_ph_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             overrun_q, overrun_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;

  astable_monitor_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .async_i  (osc_in),
    .level_o  (level_c),
    .rise_p_c (rise_c),
    .fall_p_c (fall_c)
  );

  assign edge_c = rise_c | fall_c;
  // Timeout only matters when no edge arrives in the same cycle.
  assign tmo_c  = (cnt_q >= TIMEOUT_C) && !edge_c;

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      high_ph_q   <= '0;
      valid_q     <= 1'b0;
      high_q      <= '0;
      low_q       <= '0;
      period_q    <= '0;
      overrun_q   <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_ph_q   <= high_ph_d;
      valid_q     <= valid_d;
      high_q      <= high_d;
      low_q       <= low_d;
      period_q    <= period_d;
      overrun_q   <= overrun_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  // Next-state, phase counting, publication and handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_ph_d   = high_ph_q;
    valid_d     = valid_q & ~meas_ready;
    high_d      = high_q;
    low_d       = low_q;
    period_d    = period_q;
    overrun_d   = overrun_q;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;

    // Cycles since last edge; saturates so an idle monitor never wraps.
    if (edge_c) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (edge_c) begin
      stuck_d = 1'b0;
    end

    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_c) begin
            state_d = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall_c) begin
            high_ph_d = cnt_q;
            state_d   = MEAS_LOW;
          end else if (tmo_c) begin
            stuck_d     = 1'b1;
            stuck_lvl_d = level_c;
            state_d     = IDLE;
          end
        end
        MEAS_LOW: begin
          if (rise_c) begin
            // Full rise-fall-rise seen: publish, overwriting any held result.
            valid_d  = 1'b1;
            high_d   = high_ph_q;
            low_d    = cnt_q;
            period_d = (CNT_W+1)'(high_ph_q) + (CNT_W+1)'(cnt_q);
            if (valid_q && !meas_ready) begin
              overrun_d = 1'b1;
            end
            state_d  = MEAS_HIGH;
          end else if (tmo_c) begin
            stuck_d     = 1'b1;
            stuck_lvl_d = level_c;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign meas_valid  = valid_q;
  assign high_cnt    = high_q;
  assign low_cnt     = low_q;
  assign period      = period_q;
  assign overrun     = overrun_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_lvl_q;

endmodule
